// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam int unsigned TIMEOUT_WIDTH = 16;

endpackage

// File: rtl/uart_rr_picker.sv
// Rotate-priority encoder: first set request at or after rr_ptr, cyclically.
module uart_rr_picker
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned IDX_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] rr_ptr,
  output logic                 any,
  output logic [IDX_WIDTH-1:0] winner
);

  int unsigned          pos;
  logic [IDX_WIDTH-1:0] idx;

  // Scan NUM_REQ positions starting at rr_ptr; the first hit wins.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    pos    = 0;
    idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pos = 32'(rr_ptr) + i;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      idx = IDX_WIDTH'(pos);
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte sources, round-robin per message.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned IDX_WIDTH    = 2,
  parameter int unsigned LOCK_TIMEOUT = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_transmit,
  input  logic                   tx_ready,
  output logic                   grant_valid,
  output logic [IDX_WIDTH-1:0]   grant_idx,
  output logic                   lock_broken
);

  state_t                   state_q, state_d;
  logic [IDX_WIDTH-1:0]     rr_ptr;
  logic [IDX_WIDTH-1:0]     pick_idx;
  logic [IDX_WIDTH-1:0]     issue_idx;
  logic [IDX_WIDTH-1:0]     next_ptr;
  logic                     pick_any;
  logic                     locked;
  logic                     start_issue;
  logic                     lock_idle;
  logic                     lock_fire;
  logic [TIMEOUT_WIDTH-1:0] lock_cnt;
  logic [NUM_REQ-1:0]       issue_onehot;

  uart_rr_picker #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_picker (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .any    (pick_any),
    .winner (pick_idx)
  );

  assign issue_idx    = locked ? grant_idx : pick_idx;
  assign issue_onehot = NUM_REQ'(1) << issue_idx;
  assign next_ptr     = (grant_idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_WIDTH'(1);

  // Idle while the owner of a lock has nothing to send; fires on the LOCK_TIMEOUT-th such cycle.
  assign lock_idle = (state_q == IDLE) && locked && !req_valid[grant_idx];
  assign lock_fire = (LOCK_TIMEOUT != 0) && lock_idle &&
                     (lock_cnt == TIMEOUT_WIDTH'(LOCK_TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; a locked owner is the only candidate in IDLE.
  always_comb begin
    state_d     = state_q;
    start_issue = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_ready && (locked ? req_valid[grant_idx] : pick_any)) begin
          state_d     = ISSUE;
          start_issue = 1'b1;
        end
      end
      ISSUE:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (!tx_ready) state_d = WAIT_DONE;
      WAIT_DONE: if (tx_ready)  state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Grant, lock, round-robin pointer and the registered transmit/handshake pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      locked      <= 1'b0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      tx_transmit <= 1'b0;
      tx_data     <= '0;
      req_ready   <= '0;
      lock_broken <= 1'b0;
    end else begin
      tx_transmit <= 1'b0;
      req_ready   <= '0;
      lock_broken <= 1'b0;
      if (start_issue) begin
        tx_transmit <= 1'b1;
        tx_data     <= req_data[{issue_idx, 3'b000} +: 8];
        req_ready   <= issue_onehot;
        grant_idx   <= issue_idx;
        grant_valid <= 1'b1;
      end
      if (state_q == ISSUE) begin
        locked <= ~req_last[grant_idx];
      end
      if ((state_q == WAIT_DONE) && tx_ready && !locked) begin
        rr_ptr      <= next_ptr;
        grant_valid <= 1'b0;
      end
      if (lock_fire) begin
        locked      <= 1'b0;
        grant_valid <= 1'b0;
        rr_ptr      <= next_ptr;
        lock_broken <= 1'b1;
      end
    end
  end

  // Lock timeout counter: counts starved IDLE cycles, cleared outside IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt <= '0;
    end else if ((state_q != IDLE) || lock_fire) begin
      lock_cnt <= '0;
    end else if (lock_idle && (LOCK_TIMEOUT != 0)) begin
      lock_cnt <= lock_cnt + TIMEOUT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a transmitter model and queued requesters.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int CHAR    = 4;

  typedef struct {
    int         cyc;
    logic [1:0] idx;
    logic [7:0] data;
    logic [3:0] rdy;
  } tx_ev_t;

  typedef struct {
    int   cyc;
    logic gv;
  } lb_ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_transmit;
  logic        tx_ready;
  logic        grant_valid;
  logic [1:0]  grant_idx;
  logic        lock_broken;
  logic        tx_hold = 1'b0;

  int          cyc = 0;
  int          busy = 0;
  int          overlap = 0;
  int          rdy_cnt = 0;
  int          checks = 0;
  int          failures = 0;
  int          rise_cyc [NUM_REQ];
  logic [3:0]  pend = '0;
  logic [8:0]  q [NUM_REQ][$];
  tx_ev_t      log_q [$];
  lb_ev_t      lb_q [$];

  uart_tx_arbiter #(
    .NUM_REQ      (4),
    .IDX_WIDTH    (2),
    .LOCK_TIMEOUT (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_transmit (tx_transmit),
    .tx_ready    (tx_ready),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .lock_broken (lock_broken)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: ready drops the cycle after a transmit pulse, for CHAR cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= 0;
    else if (tx_transmit) busy <= CHAR;
    else if (busy != 0) busy <= busy - 1;
  end
  assign tx_ready = (busy == 0) && !tx_hold;

  // Requesters: present queue heads; pop one negedge after req_ready is seen.
  always @(negedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      logic [8:0] head;
      if (pend[i] && q[i].size() != 0) void'(q[i].pop_front());
      pend[i] = rst_n && req_ready[i];
      if (q[i].size() != 0) begin
        head = q[i][0];
        if (!req_valid[i]) rise_cyc[i] = cyc;
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = head[7:0];
        req_last[i]        = head[8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  end

  // Monitor: log transmits, accept pulses and lock breaks.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_transmit) begin
        log_q.push_back('{cyc, grant_idx, tx_data, req_ready});
        if (busy != 0) overlap++;
      end
      if (req_ready != 4'b0000) rdy_cnt++;
      if (lock_broken) lb_q.push_back('{cyc, grant_valid});
    end
  end

  task automatic wait_log(input int n, input string name);
    int k = 0;
    while (log_q.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (log_q.size() < n) begin
      failures++;
      $display("FAIL %s: transmits seen %0d, required %0d", name, log_q.size(), n);
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) q[i].delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, tx_transmit, tx_data, grant_valid, grant_idx, lock_broken} !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %h, required 0",
               {req_ready, tx_transmit, tx_data, grant_valid, grant_idx, lock_broken});
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (log_q.size() != 0 || grant_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_quiet: transmits %0d grant_valid %b, required 0 0", log_q.size(), grant_valid);
    end
  endtask

  task automatic test_single;
    int b;
    do_reset;
    b = log_q.size();
    @(posedge clk);
    q[2].push_back({1'b1, 8'hA5});
    wait_log(b + 1, "single_tx");
    if (log_q.size() >= b + 1) begin
      checks++;
      if (log_q[b].idx !== 2'd2 || log_q[b].data !== 8'hA5 || log_q[b].rdy !== 4'b0100) begin
        failures++;
        $display("FAIL single_byte: idx %0d data %h rdy %b, required 2 a5 0100",
                 log_q[b].idx, log_q[b].data, log_q[b].rdy);
      end
      checks++;
      if (log_q[b].cyc - rise_cyc[2] != 1) begin
        failures++;
        $display("FAIL single_latency: %0d cycles, required 1", log_q[b].cyc - rise_cyc[2]);
      end
    end
    repeat (10) @(negedge clk);
    checks++;
    if (grant_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_release: grant_valid %b, required 0", grant_valid);
    end
    // rr_ptr should now be 3: with 0 and 3 pending, 3 goes first.
    @(posedge clk);
    q[0].push_back({1'b1, 8'h11});
    q[3].push_back({1'b1, 8'h33});
    wait_log(b + 3, "single_rrptr_tx");
    if (log_q.size() >= b + 3) begin
      checks++;
      if (log_q[b+1].idx !== 2'd3 || log_q[b+2].idx !== 2'd0) begin
        failures++;
        $display("FAIL single_rrptr: order %0d,%0d, required 3,0", log_q[b+1].idx, log_q[b+2].idx);
      end
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_round_robin;
    int         b, r0, o0;
    int         exp_idx [5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_dat [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20};
    do_reset;
    b  = log_q.size();
    r0 = rdy_cnt;
    o0 = overlap;
    @(posedge clk);
    for (int i = 0; i < NUM_REQ; i++) q[i].push_back({1'b1, 8'(8'h10 + i)});
    q[0].push_back({1'b1, 8'h20});
    wait_log(b + 5, "rr_tx");
    if (log_q.size() >= b + 5) begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (log_q[b+i].idx !== 2'(exp_idx[i]) || log_q[b+i].data !== exp_dat[i] ||
            log_q[b+i].rdy !== 4'(1 << exp_idx[i])) begin
          failures++;
          $display("FAIL rr_grant%0d: idx %0d data %h rdy %b, required %0d %h %b", i,
                   log_q[b+i].idx, log_q[b+i].data, log_q[b+i].rdy,
                   exp_idx[i], exp_dat[i], 4'(1 << exp_idx[i]));
        end
      end
    end
    repeat (10) @(negedge clk);
    checks++;
    if (rdy_cnt - r0 != 5 || overlap - o0 != 0) begin
      failures++;
      $display("FAIL rr_pulses: ready pulses %0d overlaps %0d, required 5 0", rdy_cnt - r0, overlap - o0);
    end
  endtask

  task automatic test_locked_message;
    int         b;
    int         exp_idx [4] = '{1, 1, 1, 0};
    logic [7:0] exp_dat [4] = '{8'hB1, 8'hB2, 8'hB3, 8'hC0};
    b = log_q.size();
    @(posedge clk);
    q[1].push_back({1'b0, 8'hB1});
    q[1].push_back({1'b0, 8'hB2});
    q[1].push_back({1'b1, 8'hB3});
    q[0].push_back({1'b1, 8'hC0});
    wait_log(b + 4, "lock_tx");
    if (log_q.size() >= b + 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (log_q[b+i].idx !== 2'(exp_idx[i]) || log_q[b+i].data !== exp_dat[i]) begin
          failures++;
          $display("FAIL lock_byte%0d: idx %0d data %h, required %0d %h", i,
                   log_q[b+i].idx, log_q[b+i].data, exp_idx[i], exp_dat[i]);
        end
      end
      checks++;
      if (log_q[b+1].cyc - log_q[b].cyc != CHAR + 3 || log_q[b+2].cyc - log_q[b+1].cyc != CHAR + 3) begin
        failures++;
        $display("FAIL lock_spacing: %0d %0d cycles, required %0d", log_q[b+1].cyc - log_q[b].cyc,
                 log_q[b+2].cyc - log_q[b+1].cyc, CHAR + 3);
      end
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_lock_timeout;
    int b, l;
    b = log_q.size();
    l = lb_q.size();
    @(posedge clk);
    q[3].push_back({1'b0, 8'hD3});
    q[0].push_back({1'b1, 8'hE0});
    wait_log(b + 2, "timeout_tx");
    checks++;
    if (lb_q.size() != l + 1) begin
      failures++;
      $display("FAIL timeout_pulses: %0d lock_broken pulses, required 1", lb_q.size() - l);
    end
    if (log_q.size() >= b + 2 && lb_q.size() >= l + 1) begin
      checks++;
      if (log_q[b].idx !== 2'd3 || lb_q[l].cyc - log_q[b].cyc != 14 || lb_q[l].gv !== 1'b0) begin
        failures++;
        $display("FAIL timeout_break: first idx %0d, break after %0d cycles gv %b, required 3 14 0",
                 log_q[b].idx, lb_q[l].cyc - log_q[b].cyc, lb_q[l].gv);
      end
      checks++;
      if (log_q[b+1].idx !== 2'd0 || log_q[b+1].data !== 8'hE0 || log_q[b+1].cyc - log_q[b].cyc != 15) begin
        failures++;
        $display("FAIL timeout_next: idx %0d data %h after %0d cycles, required 0 e0 15",
                 log_q[b+1].idx, log_q[b+1].data, log_q[b+1].cyc - log_q[b].cyc);
      end
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_tx_busy;
    int b, r0, rel;
    @(negedge clk);
    tx_hold = 1'b1;
    b  = log_q.size();
    r0 = rdy_cnt;
    @(posedge clk);
    q[1].push_back({1'b1, 8'h51});
    q[2].push_back({1'b1, 8'h52});
    repeat (20) @(negedge clk);
    checks++;
    if (log_q.size() != b || rdy_cnt != r0) begin
      failures++;
      $display("FAIL busy_stall: transmits %0d ready pulses %0d, required 0 0", log_q.size() - b, rdy_cnt - r0);
    end
    @(negedge clk);
    rel = cyc;
    tx_hold = 1'b0;
    wait_log(b + 2, "busy_tx");
    if (log_q.size() >= b + 2) begin
      checks++;
      if (log_q[b].cyc != rel + 1 || log_q[b].idx !== 2'd1 || log_q[b+1].idx !== 2'd2) begin
        failures++;
        $display("FAIL busy_release: delay %0d order %0d,%0d, required 1 1,2",
                 log_q[b].cyc - rel, log_q[b].idx, log_q[b+1].idx);
      end
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid_message;
    int b, t, k;
    b = log_q.size();
    @(posedge clk);
    q[2].push_back({1'b0, 8'hF1});
    q[2].push_back({1'b1, 8'hF2});
    wait_log(b + 1, "rst_first_tx");
    t = (log_q.size() > b) ? log_q[b].cyc : cyc;
    k = 0;
    while (cyc < t + 3 && k < 20) begin
      @(negedge clk);
      k++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, tx_transmit, tx_data, grant_valid, grant_idx, lock_broken} !== 16'h0) begin
      failures++;
      $display("FAIL rst_async: got %h, required 0",
               {req_ready, tx_transmit, tx_data, grant_valid, grant_idx, lock_broken});
    end
    for (int i = 0; i < NUM_REQ; i++) q[i].delete();
    repeat (2) @(posedge clk);
    @(posedge clk);
    q[0].push_back({1'b1, 8'h60});
    q[2].push_back({1'b1, 8'hF2});
    @(negedge clk);
    #2 rst_n = 1'b1;
    b = log_q.size();
    wait_log(b + 2, "rst_after_tx");
    if (log_q.size() >= b + 2) begin
      checks++;
      if (log_q[b].idx !== 2'd0 || log_q[b].data !== 8'h60 ||
          log_q[b+1].idx !== 2'd2 || log_q[b+1].data !== 8'hF2) begin
        failures++;
        $display("FAIL rst_after: %0d/%h then %0d/%h, required 0/60 then 2/f2",
                 log_q[b].idx, log_q[b].data, log_q[b+1].idx, log_q[b+1].data);
      end
    end
    repeat (10) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_locked_message;
    test_lock_timeout;
    test_tx_busy;
    test_reset_mid_message;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
